robertson_scheduler: RTL and testbench
======================================

# robertson_scheduler

Sequencer and two-port round-robin arbiter for the 8-bit Robertson signed multiplier. It accepts multiply requests from two requesters over valid/ready handshakes and drives the multiplier's enable and shared 8-bit input bus (multiplicand, then multiplier). It waits for done, collects the 16-bit product from the shared 8-bit output bus (A byte, then Q byte), and returns it to the originating requester. A watchdog turns a hung multiplier into an error response.

## Interface
- TIMEOUT, 64, maximum cycles spent in WAIT before the operation aborts with an error (legal range 4..255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_m  in  16  multiplicands, signed; [7:0] = requester 0, [15:8] = requester 1
- req_q  in  16  multipliers, signed; same packing as req_m
- req_ready  out  2  one-cycle accept pulse to the granted requester
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  index of the requester the response belongs to
- rsp_product  out  16  signed product {A, Q}
- rsp_err  out  1  watchdog abort; rsp_product is 0 when set
- mul_enable  out  1  multiplier start/enable, held for the whole operation
- mul_inbus  out  8  multiplier input bus
- mul_done  in  1  multiplier done
- mul_outbus  in  8  multiplier output bus
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD_M, LOAD_Q, WAIT, READ_HI, READ_LO, RESP.
- IDLE
  - If any req_valid bit is set, grant one requester and pulse its req_ready for that cycle.
  - Latch that requester's M, Q and id, then go to LOAD_M.
  - No grant while rsp_valid is high; the FSM is never in IDLE with a response pending.
- Arbitration is round robin:
  - The last_grant register resets to 1, so requester 0 wins the first contention.
  - With both valid, grant !last_grant. With one valid, grant that one.
  - last_grant updates on every grant.
- LOAD_M: mul_enable=1, mul_inbus=latched M, then go to LOAD_Q.
- LOAD_Q: mul_enable=1, mul_inbus=latched Q, then go to WAIT and clear the watchdog counter.
- WAIT
  - mul_enable=1, mul_inbus=0.
  - When mul_done is sampled high, go to READ_HI.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with mul_done still low, set err, clear the product and go to RESP.
  - A mul_done on the timeout cycle takes priority: normal path, no error.
- READ_HI: mul_enable=1, capture mul_outbus into product[15:8], then go to READ_LO.
- READ_LO: mul_enable=1, capture mul_outbus into product[7:0], then go to RESP.
- RESP
  - mul_enable=0, rsp_valid=1, with rsp_id, rsp_product and rsp_err stable.
  - When rsp_valid && rsp_ready, go to IDLE.
- mul_enable drops to 0 in RESP and IDLE. This guarantees at least one low cycle between consecutive operations, so the multiplier sees a fresh start.
- Product width: 8x8 signed gives a 16-bit two's-complement result. No saturation or truncation; the value is passed through exactly as read.
- Requests not granted stay pending. A requester must hold req_valid and its operands until it receives req_ready.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0, mul_enable=0, mul_inbus=0, busy=0. State=IDLE, last_grant=1, watchdog=0.
- Reset asserted mid-operation: all of the above return to reset values immediately and asynchronously. The in-flight request is dropped with no response.
- All outputs are registered, except req_ready, which is decoded from the IDLE state and req_valid in the grant cycle.
- Latency, req_valid high in IDLE to rsp_valid high: 5 + W cycles, where W = cycles in WAIT including the cycle mul_done is sampled (W >= 1).
- Throughput: with rsp_ready tied high, one operation per 6 + W cycles (RESP → IDLE → grant).
- Timeout response: TIMEOUT cycles in WAIT, then RESP with rsp_err=1.
- req_ready is never high while busy=1.

## Test plan
- **Single request.** Requester 0 sends M=5, Q=-3. The multiplier model asserts done after 8 WAIT cycles and drives 0xFF then 0xF1. Required response: rsp_id=0, rsp_product=16'hFFF1, rsp_err=0, latency 13 cycles.
- **Extreme operands.** M=-128, Q=-128 with the model driving 0x40, 0x00. Required: rsp_product=16'h4000.
- **Round robin.** Both requesters hold req_valid continuously for 4 operations. Required: grant order 0,1,0,1, and a single req_ready pulse per operation.
- **Response backpressure.** Hold rsp_ready=0 for 10 cycles during RESP. Required: rsp_valid and the payload stay stable, no new req_ready, and mul_enable stays 0.
- **Watchdog.** mul_done is never asserted, with TIMEOUT=16. Required: rsp_err=1 and rsp_product=0 after 16 WAIT cycles, then the next request completes normally.
- **Reset mid-operation.** Assert rst_n low during WAIT. Required: all outputs return to reset values the same cycle, no response is issued, and the first request after reset is granted to requester 0 under contention.

Source files
------------

// File: rtl/robertson_scheduler_if.sv
// Bundle of the request, response and multiplier-side signals of
// robertson_scheduler.
//   req_valid/req_m/req_q/req_ready : two-requester multiply request handshake
//   rsp_valid/rsp_ready/rsp_id/rsp_product/rsp_err : response handshake
//   mul_enable/mul_inbus/mul_done/mul_outbus : Robertson multiplier bus
//   busy : scheduler is not idle
// slave  = the scheduler side, master = the environment around it.
interface robertson_scheduler_if;
    logic [1:0]  req_valid;
    logic [15:0] req_m;
    logic [15:0] req_q;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_product;
    logic        rsp_err;
    logic        mul_enable;
    logic [7:0]  mul_inbus;
    logic        mul_done;
    logic [7:0]  mul_outbus;
    logic        busy;

    modport slave (
        input  req_valid, req_m, req_q, rsp_ready, mul_done, mul_outbus,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mul_enable, mul_inbus, busy
    );

    modport master (
        output req_valid, req_m, req_q, rsp_ready, mul_done, mul_outbus,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mul_enable, mul_inbus, busy
    );
endinterface

// File: rtl/robertson_scheduler.sv
// Sequencer and two-port round-robin arbiter for the 8-bit Robertson signed
// multiplier. Grants one requester, streams M then Q over mul_inbus, waits for
// mul_done (guarded by a watchdog), reads the product as A byte then Q byte
// from mul_outbus and returns it with the requester id.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : robertson_scheduler_if.slave (request, response, multiplier bus)
// Parameter TIMEOUT: cycles allowed in WAIT before an error response (4..255).
module robertson_scheduler #(
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    robertson_scheduler_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, LOAD_M, LOAD_Q, WAIT, READ_HI, READ_LO, RESP
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  op_m_q, op_m_d;
    logic [7:0]  op_q_q, op_q_d;
    logic [7:0]  wd_cnt_q, wd_cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_product_q, rsp_product_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mul_enable_q, mul_enable_d;
    logic [7:0]  mul_inbus_q, mul_inbus_d;
    logic        busy_q, busy_d;

    logic gnt_any;
    logic gnt_id;
    logic wd_expire;

    // Grant only from IDLE; with both requesting, alternate away from the last
    // winner, otherwise take whichever one is requesting.
    assign gnt_any   = (state_q == IDLE) && !rsp_valid_q && (|bus.req_valid);
    assign gnt_id    = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    assign wd_expire = (state_q == WAIT) && !bus.mul_done && (wd_cnt_q == TO_LAST);

    assign bus.req_ready   = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mul_enable  = mul_enable_q;
    assign bus.mul_inbus   = mul_inbus_q;
    assign bus.busy        = busy_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_any) state_d = LOAD_M;
            LOAD_M:  state_d = LOAD_Q;
            LOAD_Q:  state_d = WAIT;
            WAIT: begin
                // done on the expiry cycle still wins over the watchdog
                if (bus.mul_done)   state_d = READ_HI;
                else if (wd_expire) state_d = RESP;
            end
            READ_HI: state_d = READ_LO;
            READ_LO: state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic. Registered outputs are computed from state_d
    // so they line up with the state being entered.
    always_comb begin
        last_grant_d  = last_grant_q;
        op_m_d        = op_m_q;
        op_q_d        = op_q_q;
        wd_cnt_d      = wd_cnt_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;

        if (gnt_any) begin
            last_grant_d  = gnt_id;
            rsp_id_d      = gnt_id;
            op_m_d        = gnt_id ? bus.req_m[15:8] : bus.req_m[7:0];
            op_q_d        = gnt_id ? bus.req_q[15:8] : bus.req_q[7:0];
            rsp_err_d     = 1'b0;
            rsp_product_d = 16'h0000;
        end

        unique case (state_q)
            LOAD_Q:  wd_cnt_d = 8'd0;
            WAIT: begin
                if (wd_expire) begin
                    rsp_err_d     = 1'b1;
                    rsp_product_d = 16'h0000;
                end else if (!bus.mul_done) begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            READ_HI: rsp_product_d[15:8] = bus.mul_outbus;
            READ_LO: rsp_product_d[7:0]  = bus.mul_outbus;
            default: ;
        endcase

        // mul_enable low in IDLE and RESP gives the multiplier a fresh start
        mul_enable_d = (state_d != IDLE) && (state_d != RESP);
        rsp_valid_d  = (state_d == RESP);
        busy_d       = (state_d != IDLE);
        unique case (state_d)
            LOAD_M:  mul_inbus_d = op_m_d;
            LOAD_Q:  mul_inbus_d = op_q_d;
            default: mul_inbus_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= 1'b1;
            op_m_q        <= 8'h00;
            op_q_q        <= 8'h00;
            wd_cnt_q      <= 8'd0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_product_q <= 16'h0000;
            rsp_err_q     <= 1'b0;
            mul_enable_q  <= 1'b0;
            mul_inbus_q   <= 8'h00;
            busy_q        <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            op_m_q        <= op_m_d;
            op_q_q        <= op_q_d;
            wd_cnt_q      <= wd_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
            mul_enable_q  <= mul_enable_d;
            mul_inbus_q   <= mul_inbus_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_robertson_scheduler.sv
// Self-checking bench for robertson_scheduler: behavioural Robertson
// multiplier model on the multiplier bus, scoreboard of expected responses
// pushed at grant time and popped on each response handshake.
module tb_robertson_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    robertson_scheduler_if bus_if();

    robertson_scheduler #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_rsp  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic        id;
        logic [15:0] prod;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   exp_gnt[$];

    // ---------------- multiplier model ----------------
    bit         hang   = 1'b0;
    int         wait_w = 8;
    int         en_cnt = 0;
    logic [7:0] mm, mq;
    logic [15:0] prod;
    assign prod = {{8{mm[7]}}, mm} * {{8{mq[7]}}, mq};

    // Counts enable-high cycles: 1 = M on inbus, 2 = Q, done on the
    // wait_w-th WAIT cycle, then A byte and Q byte.
    always @(negedge clk) begin
        if (!bus_if.mul_enable) begin
            en_cnt            <= 0;
            bus_if.mul_done   <= 1'b0;
            bus_if.mul_outbus <= 8'h00;
        end else begin
            en_cnt <= en_cnt + 1;
            if (en_cnt + 1 == 1) mm <= bus_if.mul_inbus;
            if (en_cnt + 1 == 2) mq <= bus_if.mul_inbus;
            bus_if.mul_done <= !hang && (en_cnt + 1 == 2 + wait_w);
            if (en_cnt + 1 == 3 + wait_w)      bus_if.mul_outbus <= prod[15:8];
            else if (en_cnt + 1 == 4 + wait_w) bus_if.mul_outbus <= prod[7:0];
            else                               bus_if.mul_outbus <= 8'h00;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.req_ready != 2'b00) begin
                chk("ready_onehot", 32'($onehot(bus_if.req_ready)), 32'd1);
                chk("ready_while_busy", bus_if.busy, 1'b0);
                if (exp_gnt.size() > 0) chk("grant_order", bus_if.req_ready[1], exp_gnt.pop_front());
            end
            if (bus_if.rsp_valid) chk("rsp_mul_enable", bus_if.mul_enable, 1'b0);
            if (bus_if.rsp_valid && bus_if.rsp_ready) begin
                n_rsp++;
                chk("rsp_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    chk("rsp_id", bus_if.rsp_id, sb[0].id);
                    chk("rsp_product", bus_if.rsp_product, sb[0].prod);
                    chk("rsp_err", bus_if.rsp_err, sb[0].err);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req_op(input int id, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp_p, input logic exp_e);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus_if.req_valid[id]     = 1'b1;
        bus_if.req_m[id*8 +: 8]  = m;
        bus_if.req_q[id*8 +: 8]  = q;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus_if.req_ready[id]) got = 1'b1;
        end
        chk("grant_seen", got, 1'b1);
        if (got) sb.push_back('{id: id[0], prod: exp_p, err: exp_e});
        @(posedge clk); #1;
        bus_if.req_valid[id] = 1'b0;
    endtask

    // Cycles from the grant (req_ready) to rsp_valid.
    task automatic measure_lat(input int id, input int exp_lat);
        int k = 0;
        int n = 0;
        while (!bus_if.req_ready[id] && k < 300) begin @(negedge clk); k++; end
        while (!bus_if.rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("latency", n, exp_lat);
    endtask

    task automatic drain();
        int i = 0;
        while ((sb.size() != 0 || bus_if.busy) && i < 500) begin @(negedge clk); i++; end
        chk("drained", (sb.size() == 0) && !bus_if.busy, 1'b1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_req_ready", bus_if.req_ready, 2'b00);
        chk("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
        chk("rst_rsp_id", bus_if.rsp_id, 1'b0);
        chk("rst_rsp_product", bus_if.rsp_product, 16'h0000);
        chk("rst_rsp_err", bus_if.rsp_err, 1'b0);
        chk("rst_mul_enable", bus_if.mul_enable, 1'b0);
        chk("rst_mul_inbus", bus_if.mul_inbus, 8'h00);
        chk("rst_busy", bus_if.busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rsp_before;
        bus_if.req_valid = 2'b00;
        bus_if.req_m     = 16'h0000;
        bus_if.req_q     = 16'h0000;
        bus_if.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst_n = 1'b1;

        // single request, latency 5 + 8
        fork
            req_op(0, 8'd5, 8'hFD, 16'hFFF1, 1'b0);
            measure_lat(0, 13);
        join
        drain();

        // extreme operands from requester 1
        req_op(1, 8'h80, 8'h80, 16'h4000, 1'b0);
        drain();

        // round robin with both requesters held
        exp_gnt = '{0, 1, 0, 1};
        fork
            begin
                req_op(0, 8'd12, 8'hF9, 16'hFFAC, 1'b0);
                req_op(0, 8'h9C, 8'h64, 16'hD8F0, 1'b0);
            end
            begin
                req_op(1, 8'd127, 8'd127, 16'h3F01, 1'b0);
                req_op(1, 8'hFF, 8'h01, 16'hFFFF, 1'b0);
            end
        join
        drain();
        chk("grants_consumed", exp_gnt.size(), 0);

        // response backpressure with a competing request pending
        bus_if.rsp_ready = 1'b0;
        req_op(0, 8'd7, 8'd9, 16'd63, 1'b0);
        for (int i = 0; i < 300 && !bus_if.rsp_valid; i++) @(negedge clk);
        @(posedge clk); #1;
        bus_if.req_valid[1] = 1'b1;
        bus_if.req_m[15:8]  = 8'd2;
        bus_if.req_q[15:8]  = 8'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus_if.rsp_valid, 1'b1);
            chk("bp_rsp_product", bus_if.rsp_product, 16'd63);
            chk("bp_rsp_id", bus_if.rsp_id, 1'b0);
            chk("bp_req_ready", bus_if.req_ready, 2'b00);
            chk("bp_mul_enable", bus_if.mul_enable, 1'b0);
        end
        @(posedge clk); #1;
        bus_if.req_valid[1] = 1'b0;
        bus_if.rsp_ready    = 1'b1;
        drain();

        // watchdog: 16 WAIT cycles then error response
        hang = 1'b1;
        fork
            req_op(1, 8'd3, 8'd3, 16'h0000, 1'b1);
            measure_lat(1, 19);
        join
        drain();
        hang = 1'b0;
        req_op(0, 8'd3, 8'd4, 16'd12, 1'b0);
        drain();

        // reset during WAIT
        hang = 1'b1;
        req_op(0, 8'd9, 8'd9, 16'd81, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_reset_mul_enable", bus_if.mul_enable, 1'b1);
        rsp_before = n_rsp;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hang  = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_rsp_after_reset", n_rsp, rsp_before);
        exp_gnt = '{0, 1};
        fork
            req_op(0, 8'd6, 8'hFE, 16'hFFF4, 1'b0);
            req_op(1, 8'd10, 8'd10, 16'd100, 1'b0);
        join
        drain();
        chk("post_reset_grants", exp_gnt.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
